// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: 2-flop synchronizer, glitch filter, Gray-phase tracker, loadable position count.
// Define QUAD_SATURATE_EN to clamp the count at its limits instead of wrapping.
module quad_step_decoder #(
  parameter int WIDTH  = 8,
  parameter int FILTER = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             qa,
  input  logic             qb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             ovf
);

  typedef enum logic [1:0] {P00 = 2'b00, P01 = 2'b01, P11 = 2'b11, P10 = 2'b10} phase_t;

  logic [1:0] s1, s2;
  logic [1:0] filt, cand;
  logic [3:0] cnt, hits;
  phase_t     state, next_state;
  logic       up, dn, bad;
  logic       at_max, at_min;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {qa, qb};
      s2 <= s1;
    end
  end

  // Run length of the current candidate, counting this edge.
  always_comb begin
    hits = 4'd1;
    if (cnt != 4'd0 && s2 == cand) hits = cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= 2'b00;
      cand <= 2'b00;
      cnt  <= 4'd0;
    end else if (s2 == filt) begin
      cnt <= 4'd0;
    end else if (hits >= 4'(FILTER)) begin
      filt <= s2;
      cnt  <= 4'd0;
    end else begin
      cand <= s2;
      cnt  <= hits;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= P00;
    else       state <= next_state;
  end

  always_comb begin
    next_state = phase_t'(filt);
  end

  always_comb begin
    up  = 1'b0;
    dn  = 1'b0;
    bad = ((state ^ next_state) == 2'b11);
    case (state)
      P00: begin up = (next_state == P01); dn = (next_state == P10); end
      P01: begin up = (next_state == P11); dn = (next_state == P00); end
      P11: begin up = (next_state == P10); dn = (next_state == P01); end
      P10: begin up = (next_state == P00); dn = (next_state == P11); end
      default: ;
    endcase
  end

  assign at_max = (count == {WIDTH{1'b1}});
  assign at_min = (count == {WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= bad;
      ovf  <= 1'b0;
      if ((up || dn) && en) begin
        step <= 1'b1;
        dir  <= up;
`ifdef QUAD_SATURATE_EN
        if ((up && at_max) || (dn && at_min)) ovf <= !load;
        else count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
`else
        count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
        ovf   <= !load && (up ? at_max : at_min);
`endif
      end
      // A load wins over any step arithmetic on the same edge.
      if (load) count <= load_data;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Randomized and directed bench for quad_step_decoder against a phase-index reference model.
module tb_quad_step_decoder;
  localparam int WIDTH  = 8;
  localparam int FILTER = 2;
  localparam int MAXV   = (1 << WIDTH) - 1;
`ifdef QUAD_SATURATE_EN
  localparam int UNDER = 0;
`else
  localparam int UNDER = MAXV;
`endif

  logic clk = 0, reset = 1, en = 1, qa = 0, qb = 0, load = 0;
  logic [WIDTH-1:0] load_data = '0;
  logic [WIDTH-1:0] count;
  logic step, dir, err, ovf;

  quad_step_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
    .clk(clk), .reset(reset), .en(en), .qa(qa), .qb(qb), .load(load),
    .load_data(load_data), .count(count), .step(step), .dir(dir), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int steps_seen = 0, errs_seen = 0;
  bit started = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position of a phase in the up sequence 00,01,11,10.
  function automatic int idx(input logic [1:0] p);
    case (p)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model: pins delayed two edges, accepted after FILTER equal samples, then decoded by index distance.
  logic [1:0] mp1, mp2, m_runval, m_filt, m_ph;
  int m_run, m_count, d;
  bit m_step, m_dir, m_err, m_ovf;

  task automatic model_step();
    if (reset) begin
      mp1 = 0; mp2 = 0; m_runval = 0; m_filt = 0; m_ph = 0; m_run = 0;
      m_count = 0; m_step = 0; m_dir = 0; m_err = 0; m_ovf = 0;
    end else begin
      d = (idx(m_filt) - idx(m_ph) + 4) % 4;
      m_step = 0; m_err = 0; m_ovf = 0;
      if (d == 2) m_err = 1;
      else if (d != 0 && en) begin
        m_step = 1;
        m_dir  = (d == 1);
        if (d == 1 && m_count == MAXV) begin
          m_ovf = 1;
`ifndef QUAD_SATURATE_EN
          m_count = 0;
`endif
        end else if (d == 3 && m_count == 0) begin
          m_ovf = 1;
`ifndef QUAD_SATURATE_EN
          m_count = MAXV;
`endif
        end else m_count = (d == 1) ? m_count + 1 : m_count - 1;
        if (load) m_ovf = 0;
      end
      if (load) m_count = int'(load_data);
      m_ph = m_filt;
      if (m_run > 0 && mp2 == m_runval) m_run++;
      else begin m_runval = mp2; m_run = 1; end
      if (mp2 != m_filt && m_run >= FILTER) m_filt = mp2;
      mp2 = mp1;
      mp1 = {qa, qb};
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("count", int'(count), m_count);
      chk("step", int'(step), int'(m_step));
      chk("dir", int'(dir), int'(m_dir));
      chk("err", int'(err), int'(m_err));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (step) steps_seen++;
      if (err)  errs_seen++;
    end
  end

  task automatic setp(input logic [1:0] v);
    @(negedge clk);
    {qa, qb} = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {qa, qb} = 2'b00;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  int snap_s, snap_e;

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    started = 1;

    // 1: up sequence, first step on edge 5
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    snap_s = steps_seen;
    setp(2'b01);
    repeat (4) @(posedge clk);
    #1 chk("t1_no_step_e4", int'(step), 0);
    @(posedge clk);
    #1 chk("t1_step_e5", int'(step), 1);
    chk("t1_dir_e5", int'(dir), 1);
    hold(4);
    setp(2'b11); hold(8);
    setp(2'b10); hold(8);
    setp(2'b00); hold(8);
    chk("t1_count", int'(count), 4);
    chk("t1_model_count", m_count, 4);
    chk("t1_steps", steps_seen - snap_s, 4);

    // 2: down sequence, then underflow
    setp(2'b10); hold(8);
    setp(2'b11); hold(8);
    setp(2'b01); hold(8);
    setp(2'b00); hold(8);
    chk("t2_count", int'(count), 0);
    chk("t2_dir", int'(dir), 0);
    setp(2'b10);
    repeat (5) @(posedge clk);
    #1 chk("t2_under_count", int'(count), UNDER);
    chk("t2_under_ovf", int'(ovf), 1);
    hold(8);

    // 3: glitch rejection, 2-cycle hold accepted
    do_reset();
    snap_s = steps_seen; snap_e = errs_seen;
    setp(2'b10);
    setp(2'b00);
    hold(10);
    chk("t3_glitch_steps", steps_seen - snap_s, 0);
    chk("t3_glitch_errs", errs_seen - snap_e, 0);
    chk("t3_glitch_count", int'(count), 0);
    setp(2'b10); hold(1);
    setp(2'b00); hold(10);
    chk("t3_hold_steps", steps_seen - snap_s, 2);

    // 4: double-bit change
    do_reset();
    snap_s = steps_seen; snap_e = errs_seen;
    setp(2'b11); hold(8);
    chk("t4_errs", errs_seen - snap_e, 1);
    chk("t4_steps", steps_seen - snap_s, 0);
    chk("t4_count", int'(count), 0);
    chk("t4_dir", int'(dir), 0);
    setp(2'b10); hold(8);
    chk("t4_after_count", int'(count), 1);
    chk("t4_after_dir", int'(dir), 1);

    // 5: load coincident with an up step
    do_reset();
    setp(2'b01);
    repeat (4) @(posedge clk);
    #1 load = 1; load_data = 8'hF0;
    @(posedge clk);
    #1 chk("t5_count", int'(count), 8'hF0);
    chk("t5_step", int'(step), 1);
    chk("t5_dir", int'(dir), 1);
    chk("t5_ovf", int'(ovf), 0);
    load = 0;
    hold(8);

    // 6: enable gating, then reset mid-filter
    do_reset();
    en = 0;
    snap_s = steps_seen;
    setp(2'b01); hold(8);
    setp(2'b11); hold(8);
    en = 1;
    setp(2'b10); hold(8);
    chk("t6_count", int'(count), 1);
    chk("t6_steps", steps_seen - snap_s, 1);
    setp(2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_dir", int'(dir), 0);
    chk("t6_rst_step", int'(step), 0);
    reset = 0;
    hold(10);

    // Random phases, enables, loads and occasional resets
    for (int i = 0; i < 400; i++) begin
      setp(2'($urandom_range(3)));
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        en        = ($urandom % 5) != 0;
        load      = ($urandom % 12) == 0;
        load_data = WIDTH'($urandom);
        reset     = ($urandom % 150) == 0;
        @(negedge clk);
      end
    end
    reset = 0; load = 0;
    hold(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Receive side of the up/down counting interface: decodes a 2-phase quadrature pair (qa, qb) into step/direction events.
- Keeps a loadable position count driven by those events.
- Inputs pass through a synchronizer and a glitch filter, then a 4-state Gray-phase tracker.
- Sits between off-chip encoder pins and the datapath that consumes position and up/down step commands.

Parameters:
WIDTH, 8, width of position count
FILTER, 2, consecutive stable clk cycles required before a synchronized input change is accepted (legal range 1..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; phase tracking continues when low
qa  input  1  quadrature phase A, asynchronous
qb  input  1  quadrature phase B, asynchronous
load  input  1  synchronous load of count
load_data  input  WIDTH  value loaded into count
count  output  WIDTH  current position
step  output  1  one-cycle pulse per accepted legal transition
dir  output  1  direction of last accepted step (1 = up, 0 = down)
err  output  1  one-cycle pulse on illegal (double-bit) phase transition
ovf  output  1  one-cycle pulse when count wraps (or clamps, see Optional Feature)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: count=0, step=0, dir=0, err=0, ovf=0. Synchronizer flops, filtered phase and filter counter = 0; phase state = P00.
- Synchronizer: 2 flops per input (s1, s2); no logic between them.
- Filter: per-pair counter. When {s2_a,s2_b} differs from the filtered phase and stays equal to the same candidate value for FILTER consecutive edges, the filtered phase takes the candidate. If the candidate changes mid-count, the counter restarts. If it returns to the filtered value, the counter clears.
- Latency: input change held stable and applied before edge 1. Filtered phase updates on edge 2+FILTER. count/step/dir/err/ovf update on edge 3+FILTER.
- Phase states and encodings: P00=00, P01=01, P11=11, P10=10, with {qa,qb}.
- Up sequence: P00->P01->P11->P10->P00. The reverse is down.
- Same-phase re-acceptance cannot occur.
- Two-bit change (P00<->P11, P01<->P10): err pulse, step=0, count and dir unchanged, phase adopts the new value.
- Legal transition with en=1: step=1 for one cycle, dir set, count +/-1 modulo 2^WIDTH.
- Wrap (max->0 up, 0->max down): ovf=1 in the same cycle.
- en=0: phase still tracked; step, count and ovf unaffected. err still reported.
- load=1: count=load_data on the next edge, overriding any simultaneous step arithmetic. step and dir are still reported for that event; ovf=0.
- reset has priority over load and en. Reset mid-filter discards the pending candidate. After reset, the current pins are treated as new candidates against P00.

Optional Feature:
- Macro: QUAD_SATURATE_EN.
- Defined: count clamps at 2^WIDTH-1 going up and at 0 going down. ovf pulses on each attempted step beyond the limit. step/dir are still reported.
- Undefined: modulo wrap as above.

Test Plan:
1. Reset, FILTER=2, en=1. Drive phases 00->01->11->10->00, each held 8 cycles. -> Four step pulses with dir=1, count=4. First step appears on edge 5 after qb rises.
2. From count=4, drive the reverse sequence 00->10->11->01->00. -> Four steps with dir=0, count=0. Fifth down step -> count=255 with ovf=1 (with QUAD_SATURATE_EN: count=0 and ovf=1).
3. 1-cycle glitch on qa while at P00, FILTER=2. -> No step, no err, count unchanged. A 2-cycle hold is accepted as a step.
4. From P00, switch qa and qb together to 11 and hold. -> err pulses once, count and dir unchanged. A following 11->10 transition produces a normal up step.
5. load=1 with load_data=8'hF0 in the same cycle an up step is accepted. -> count=8'hF0, step=1, dir=1, ovf=0.
6. en=0 across two up transitions, then en=1 for one more. -> count increments by 1 only, and step pulses only once. Assert reset mid-filter -> all outputs 0 on the next edge.
